// File: rtl/switch_debouncer.sv
// Switch-bank conditioner: per-bit synchroniser, stability-count debounce, edge pulses.
// Optional press-to-toggle outputs are built when SWITCH_DEBOUNCE_TOGGLE_EN is defined.
module switch_debouncer #(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] switch_rise,
    output logic [WIDTH-1:0] switch_fall,
    output logic             changed,
    output logic [WIDTH-1:0] toggle
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]            sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]            sync;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]            switch_d;
    logic [WIDTH-1:0]            rise_d;
    logic [WIDTH-1:0]            fall_d;

    // Synchroniser chain runs every cycle, independent of enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= switch_raw;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Per-bit stability counter; a bit updates after STABLE_CYCLES consecutive differing samples.
    always_comb begin
        cnt_d    = cnt_q;
        switch_d = switch;
        rise_d   = '0;
        fall_d   = '0;
        if (enable) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sync[i] == switch[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_d[i]    = '0;
                    switch_d[i] = sync[i];
                    rise_d[i]   = sync[i];
                    fall_d[i]   = ~sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            switch      <= '0;
            switch_rise <= '0;
            switch_fall <= '0;
            changed     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            switch      <= switch_d;
            switch_rise <= rise_d;
            switch_fall <= fall_d;
            changed     <= |(rise_d | fall_d);
        end
    end

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    logic [WIDTH-1:0] toggle_q;

    // Each debounced press flips the bit's toggle state on the same edge as the rise pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_q ^ rise_d;
        end
    end

    assign toggle = toggle_q;
`else
    assign toggle = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: sliding-window reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_switch_debouncer;

    localparam int W  = 3;
    localparam int SS = 2;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] switch_raw = '0;
    logic [W-1:0] switch, switch_rise, switch_fall, toggle;
    logic         changed;

    int n_tests = 0;
    int n_fail  = 0;
    int rise_cnt [W];
    int fall_cnt [W];

    switch_debouncer #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(SC)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .switch_raw (switch_raw),
        .switch     (switch),
        .switch_rise(switch_rise),
        .switch_fall(switch_fall),
        .changed    (changed),
        .toggle     (toggle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw delayed by SS edges; a bit flips once the last SC enabled samples all differ from it.
    logic [W-1:0] m_sw, m_rise, m_fall, m_tog, sync_now;
    logic [W-1:0] raw_pipe [$];
    bit           win [W][$];
    bit           model_ok = 1'b0;
    bit           all_diff;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_pipe.delete();
            for (int s = 0; s < SS; s++) raw_pipe.push_back('0);
            for (int i = 0; i < W; i++) win[i].delete();
            m_sw = '0; m_rise = '0; m_fall = '0; m_tog = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            sync_now = raw_pipe.pop_front();
            raw_pipe.push_back(switch_raw);
            m_rise = '0;
            m_fall = '0;
            if (enable) begin
                for (int i = 0; i < W; i++) begin
                    win[i].push_back(sync_now[i]);
                    if (win[i].size() > SC) void'(win[i].pop_front());
                    all_diff = (win[i].size() == SC);
                    for (int k = 0; k < win[i].size(); k++)
                        if (win[i][k] == m_sw[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_sw[i]   = ~m_sw[i];
                        m_rise[i] = m_sw[i];
                        m_fall[i] = ~m_sw[i];
                        win[i].delete();
                    end
                end
            end
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
            m_tog = m_tog ^ m_rise;
`endif
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst && model_ok) begin
            check("model_switch", 32'(switch), 32'(m_sw));
            check("model_rise", 32'(switch_rise), 32'(m_rise));
            check("model_fall", 32'(switch_fall), 32'(m_fall));
            check("model_changed", 32'(changed), 32'(|(m_rise | m_fall)));
            check("model_toggle", 32'(toggle), 32'(m_tog));
            for (int i = 0; i < W; i++) begin
                rise_cnt[i] += int'(switch_rise[i]);
                fall_cnt[i] += int'(switch_fall[i]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int snap_r, snap_f;
    logic [W-1:0] exp_tog;

    initial begin
        for (int i = 0; i < W; i++) begin rise_cnt[i] = 0; fall_cnt[i] = 0; end
        #1 rst = 1'b1;
        #3;
        check("reset_switch", 32'(switch), 32'h0);
        check("reset_pulses", 32'({switch_rise, switch_fall, changed}), 32'h0);
        check("reset_toggle", 32'(toggle), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;

        // Quiet input after reset
        cyc(20);
        check("idle_switch", 32'(switch), 32'h0);
        check("idle_rise_count", 32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2]), 32'h0);

        // Clean step 000 -> 101: appears on 6th edge
        switch_raw = 3'b101;
        cyc(5);
        check("step_before", 32'(switch), 32'h0);
        cyc(1);
        check("step_switch", 32'(switch), 32'h5);
        check("step_rise", 32'(switch_rise), 32'h5);
        check("step_changed", 32'(changed), 32'h1);
        cyc(1);
        check("step_rise_gone", 32'(switch_rise), 32'h0);
        check("step_changed_gone", 32'(changed), 32'h0);

        // Bit0 bounce then steady high
        switch_raw = 3'b000;
        cyc(10);
        check("clear_switch", 32'(switch), 32'h0);
        snap_r = rise_cnt[0];
        for (int b = 0; b < 4; b++) begin
            switch_raw = (b % 2 == 0) ? 3'b001 : 3'b000;
            cyc(1);
        end
        switch_raw = 3'b001;
        cyc(5);
        check("bounce_before", 32'(switch), 32'h0);
        cyc(1);
        check("bounce_switch", 32'(switch), 32'h1);
        cyc(5);
        check("bounce_one_rise", 32'(rise_cnt[0] - snap_r), 32'h1);

        // Fall while disabled, completes exactly SC edges after re-enable
        switch_raw = 3'b111;
        cyc(8);
        check("all_high", 32'(switch), 32'h7);
        snap_f = fall_cnt[0] + fall_cnt[1] + fall_cnt[2];
        switch_raw = 3'b000;
        enable = 1'b0;
        cyc(10);
        check("disabled_hold", 32'(switch), 32'h7);
        check("disabled_no_fall", 32'(fall_cnt[0] + fall_cnt[1] + fall_cnt[2] - snap_f), 32'h0);
        enable = 1'b1;
        cyc(3);
        check("reenable_early", 32'(switch), 32'h7);
        cyc(1);
        check("reenable_switch", 32'(switch), 32'h0);
        check("reenable_fall", 32'(switch_fall), 32'h7);

        // Disable mid-count: count resumes from held value
        switch_raw = 3'b111;
        cyc(4);
        enable = 1'b0;
        cyc(5);
        check("midcount_hold", 32'(switch), 32'h0);
        enable = 1'b1;
        cyc(1);
        check("midcount_resume1", 32'(switch), 32'h0);
        cyc(1);
        check("midcount_resume2", 32'(switch), 32'h7);
        check("midcount_rise", 32'(switch_rise), 32'h7);

        // 3-cycle glitch on bit2 is rejected
        snap_f = fall_cnt[2];
        switch_raw = 3'b011;
        cyc(3);
        switch_raw = 3'b111;
        cyc(10);
        check("glitch3_switch", 32'(switch), 32'h7);
        check("glitch3_no_fall", 32'(fall_cnt[2] - snap_f), 32'h0);

        // 4-cycle glitch on bit2 just passes, then recovers
        snap_f = fall_cnt[2];
        snap_r = rise_cnt[2];
        switch_raw = 3'b011;
        cyc(4);
        switch_raw = 3'b111;
        cyc(12);
        check("glitch4_fall", 32'(fall_cnt[2] - snap_f), 32'h1);
        check("glitch4_rise", 32'(rise_cnt[2] - snap_r), 32'h1);
        check("glitch4_switch", 32'(switch), 32'h7);

        // Asynchronous reset mid-cycle clears outputs immediately
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_switch", 32'(switch), 32'h0);
        check("async_rst_pulses", 32'({switch_rise, switch_fall, changed}), 32'h0);
        check("async_rst_toggle", 32'(toggle), 32'h0);
        @(negedge clk);
        switch_raw = 3'b000;
        rst = 1'b0;
        cyc(8);
        check("post_rst_switch", 32'(switch), 32'h0);

        // Three debounced presses on bit1
        for (int p = 0; p < 3; p++) begin
            switch_raw = 3'b010;
            cyc(8);
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
            exp_tog = (p % 2 == 0) ? 3'b010 : 3'b000;
`else
            exp_tog = 3'b000;
`endif
            check("press_toggle", 32'(toggle), 32'(exp_tog));
            switch_raw = 3'b000;
            cyc(8);
            check("release_toggle", 32'(toggle), 32'(exp_tog));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
